// File: rtl/acc_queue_pkg.sv
// Shared types and defaults for the accelerator commit queue.
// The entry layout follows the core configuration widths.
package acc_queue_pkg;
    localparam int unsigned CfgXLEN              = 64;
    localparam int unsigned CfgInstrWidth        = 32;
    localparam int unsigned CfgTransIdWidth      = 3;
    localparam int unsigned AccQueueDepthDefault = 4;

    typedef struct packed {
        logic [CfgInstrWidth-1:0]   instr;
        logic [CfgXLEN-1:0]         rs1;
        logic [CfgXLEN-1:0]         rs2;
        logic [CfgTransIdWidth-1:0] trans_id;
    } acc_entry_t;
endpackage

// File: rtl/acc_commit_queue_sva.sv
// Protocol and occupancy checker, bound onto every acc_commit_queue instance.
module acc_commit_queue_sva #(
    parameter int unsigned Depth        = 4,
    parameter int unsigned TransIdWidth = 3,
    parameter int unsigned CntW         = $clog2(Depth + 1)
) (
    input logic                    clk_i,
    input logic                    rst_i,
    input logic                    commit_i,
    input logic [TransIdWidth-1:0] commit_trans_id_i,
    input logic [TransIdWidth-1:0] cm_trans_id,
    input logic [CntW-1:0]         n_total,
    input logic [CntW-1:0]         n_commit,
    input logic                    acc_valid,
    input logic                    acc_ready,
    input logic [TransIdWidth-1:0] acc_trans_id
);
    a_commit_has_entry: assert property (@(posedge clk_i) disable iff (rst_i)
        commit_i |-> (n_total > n_commit));

    a_commit_id_match: assert property (@(posedge clk_i) disable iff (rst_i)
        (commit_i && (n_total > n_commit)) |-> (commit_trans_id_i == cm_trans_id));

    a_occupancy: assert property (@(posedge clk_i) disable iff (rst_i)
        (n_commit <= n_total) && (n_total <= CntW'(Depth)));

    a_valid_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (acc_valid && !acc_ready) |=> (acc_valid && $stable(acc_trans_id)));
endmodule

bind acc_commit_queue acc_commit_queue_sva #(
    .Depth        (Depth),
    .TransIdWidth (TransIdWidth)
) u_sva (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .commit_i          (commit_i),
    .commit_trans_id_i (commit_trans_id_i),
    .cm_trans_id       (r_mem[r_cm_ptr].trans_id),
    .n_total           (r_n_total),
    .n_commit          (r_n_commit),
    .acc_valid         (acc_req_valid_o),
    .acc_ready         (acc_req_ready_i),
    .acc_trans_id      (acc_req_trans_id_o)
);

// File: rtl/acc_commit_queue.sv
// In-order speculative holding queue in front of the vector accelerator port.
// Entries are enqueued speculatively, committed in order, and dispatched once committed.
module acc_commit_queue
    import acc_queue_pkg::*;
#(
    parameter  int unsigned Depth        = AccQueueDepthDefault,
    parameter  int unsigned InstrWidth   = CfgInstrWidth,
    parameter  int unsigned XLEN         = CfgXLEN,
    parameter  int unsigned TransIdWidth = CfgTransIdWidth,
    localparam int unsigned CntW         = $clog2(Depth + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [InstrWidth-1:0]   in_instr_i,
    input  logic [XLEN-1:0]         in_rs1_i,
    input  logic [XLEN-1:0]         in_rs2_i,
    input  logic [TransIdWidth-1:0] in_trans_id_i,
    input  logic                    commit_i,
    input  logic [TransIdWidth-1:0] commit_trans_id_i,
    output logic                    acc_req_valid_o,
    input  logic                    acc_req_ready_i,
    output logic [InstrWidth-1:0]   acc_req_instr_o,
    output logic [XLEN-1:0]         acc_req_rs1_o,
    output logic [XLEN-1:0]         acc_req_rs2_o,
    output logic [TransIdWidth-1:0] acc_req_trans_id_o,
    output logic                    empty_o,
    output logic [CntW-1:0]         count_o
);
    localparam int unsigned PtrW = $clog2(Depth);

    typedef struct packed {
        logic [InstrWidth-1:0]   instr;
        logic [XLEN-1:0]         rs1;
        logic [XLEN-1:0]         rs2;
        logic [TransIdWidth-1:0] trans_id;
    } entry_t;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    entry_t          r_mem [Depth];
    logic [PtrW-1:0] r_wr_ptr, r_cm_ptr, r_rd_ptr;
    logic [CntW-1:0] r_n_total, r_n_commit;

    logic            w_enq, w_com, w_deq;
    logic [PtrW-1:0] w_wr_ptr_nxt, w_cm_ptr_nxt, w_rd_ptr_nxt;
    logic [CntW-1:0] w_n_total_nxt, w_n_commit_nxt;

    // Ready looks only at registered occupancy, so a full queue refuses even during a dispatch.
    assign in_ready_o      = (r_n_total < CntW'(Depth));
    assign acc_req_valid_o = (r_n_commit != '0);
    assign empty_o         = (r_n_total == '0);
    assign count_o         = r_n_total;

    assign acc_req_instr_o    = r_mem[r_rd_ptr].instr;
    assign acc_req_rs1_o      = r_mem[r_rd_ptr].rs1;
    assign acc_req_rs2_o      = r_mem[r_rd_ptr].rs2;
    assign acc_req_trans_id_o = r_mem[r_rd_ptr].trans_id;

    assign w_enq = in_valid_i && in_ready_o && !flush_i;
    assign w_com = commit_i && (r_n_total > r_n_commit);
    assign w_deq = acc_req_valid_o && acc_req_ready_i;

    always_comb begin
        w_cm_ptr_nxt   = w_com ? ptr_inc(r_cm_ptr) : r_cm_ptr;
        w_rd_ptr_nxt   = w_deq ? ptr_inc(r_rd_ptr) : r_rd_ptr;
        w_n_commit_nxt = r_n_commit + CntW'(w_com) - CntW'(w_deq);
        w_wr_ptr_nxt   = w_enq ? ptr_inc(r_wr_ptr) : r_wr_ptr;
        w_n_total_nxt  = r_n_total + CntW'(w_enq) - CntW'(w_deq);
        // Flush rewinds the write side to the commit boundary after this cycle's commit lands.
        if (flush_i) begin
            w_wr_ptr_nxt  = w_cm_ptr_nxt;
            w_n_total_nxt = w_n_commit_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_cm_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_n_total  <= '0;
            r_n_commit <= '0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_cm_ptr   <= w_cm_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_n_total  <= w_n_total_nxt;
            r_n_commit <= w_n_commit_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wr_ptr].instr    <= in_instr_i;
            r_mem[r_wr_ptr].rs1      <= in_rs1_i;
            r_mem[r_wr_ptr].rs2      <= in_rs2_i;
            r_mem[r_wr_ptr].trans_id <= in_trans_id_i;
        end
    end
endmodule
